sram_sp_access_ctrl: RTL and testbench



---
 rtl/sram_sp_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_sp_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_sp_access_ctrl
//
// Request-side controller for a single-port SRAM macro that has an active-low
// chip enable, an active-low write enable, synchronous write and 1-cycle
// registered read data. The controller owns all macro pins.
//
// After reset it can zero-fill the whole array (INIT). It then serves write
// and read requests (RUN). A write always wins over a read in the same cycle.
// Read data returns on a response channel one cycle after the read fires. A
// hold register keeps a response alive under backpressure, because the macro
// output is only meaningful in the cycle right after a read.
//
// Handshake rule for every channel below: a transfer happens on a rising
// clock edge where valid && ready are both 1. valid must not depend on ready.
// Once a requester raises valid, it keeps valid and its payload stable until
// the transfer happens.
//
// Ports
//   clock       sole clock; the macro CLK is tied to the same net
//   reset       asynchronous, active-high
//   w_valid     write request valid
//   w_ready     write accepted when w_valid && w_ready
//   w_addr      write address
//   w_data      write data
//   r_valid     read request valid
//   r_ready     read accepted when r_valid && r_ready
//   r_addr      read address
//   resp_valid  read response valid
//   resp_ready  consumer accepts the response
//   resp_data   read response data
//   init_done   high once the controller is in RUN
//   sram_CEB    macro chip enable, active low
//   sram_WEB    macro write enable, active low
//   sram_A      macro address
//   sram_D      macro write data
//   sram_Q      macro read data
//   dbg_state   current FSM state (0 = INIT, 1 = RUN)
// ---------------------------------------------------------------------------
module sram_sp_access_ctrl #(
  parameter int DATA_W        = 334,
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_s1_pend;    // macro output holds read data this cycle
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;

  logic w_run;
  logic w_wr_fire;
  logic w_rd_fire;

  // Reset gates the combinational outputs too. This keeps the pins idle and
  // every ready low for as long as reset is held, even though the state
  // register already shows INIT.
  assign w_run     = (r_state == ST_RUN) && !reset;
  assign w_wr_fire = w_run && w_valid;

  // A read may only fire when its response has somewhere to go next cycle.
  // No hold is occupied, and any response now on the output is being taken.
  assign r_ready   = w_run && !w_valid && !r_hold_valid &&
                     !(r_s1_pend && !resp_ready);
  assign w_rd_fire = r_valid && r_ready;

  assign w_ready   = w_run;
  assign init_done = w_run;
  assign dbg_state = r_state;

  // Macro pin drive
  always_comb begin
    sram_CEB = 1'b1;
    sram_WEB = 1'b1;
    sram_A   = '0;
    sram_D   = '0;
    if (!reset) begin
      if (r_state == ST_INIT) begin
        sram_CEB = 1'b0;
        sram_WEB = 1'b0;
        sram_A   = r_init_cnt;
      end else if (w_wr_fire) begin
        sram_CEB = 1'b0;
        sram_WEB = 1'b0;
        sram_A   = w_addr;
        sram_D   = w_data;
      end else if (w_rd_fire) begin
        sram_CEB = 1'b0;
        sram_A   = r_addr;
      end
    end
  end

  // Response: live macro data in the cycle after the read, else the hold copy
  assign resp_valid = r_s1_pend || r_hold_valid;
  assign resp_data  = r_s1_pend ? sram_Q : r_hold_data;

  // FSM and init counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_ADDR) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Read pipeline and hold register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_pend    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_s1_pend <= w_rd_fire;
      if (r_s1_pend && !resp_ready) begin
        // Capture now: the macro output becomes garbage next cycle
        r_hold_valid <= 1'b1;
        r_hold_data  <= sram_Q;
      end else if (r_hold_valid && resp_ready) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Simulation checks
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(r_s1_pend && r_hold_valid))
        else $error("s1_pend and hold_valid both set");
      if (w_wr_fire) begin
        assert (32'(w_addr) < DEPTH) else $error("write address out of range");
      end
      if (w_rd_fire) begin
        assert (32'(r_addr) < DEPTH) else $error("read address out of range");
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_access_ctrl
//
// Directed testbench for sram_sp_access_ctrl. It includes a behavioural model
// of the single-port macro. The model drives random garbage on Q in every
// cycle that does not follow a read. Inputs change 1 time unit after the
// rising edge. Outputs are sampled 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_sram_sp_access_ctrl;

  localparam int DATA_W = 334;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              r_valid = 1'b0;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_CEB;
  logic              sram_WEB;
  logic [ADDR_W-1:0] sram_A;
  logic [DATA_W-1:0] sram_D;
  logic [DATA_W-1:0] sram_Q = '0;
  logic [0:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  sram_sp_access_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A),
    .sram_D(sram_D), .sram_Q(sram_Q),
    .dbg_state(dbg_state)
  );

  // ---------------- macro model ----------------
  // Nonzero power-up contents, so the zero-fill is visible
  logic [DATA_W-1:0] mem [DEPTH] = '{default: 334'hBAD_F00D};

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < (DATA_W + 31) / 32; k++) begin
      v = {v[DATA_W-33:0], 32'($urandom())};
    end
    return v;
  endfunction

  always @(posedge clock) begin
    if (!sram_CEB && !sram_WEB) mem[sram_A] <= sram_D;
    if (!sram_CEB && sram_WEB) sram_Q <= mem[sram_A];
    else                       sram_Q <= rand_word();
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    w_valid = 1'b0;
    r_valid = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    r_addr  = '0;
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_ceb"}, sram_CEB, 1'b1);
    check({tag, "_web"}, sram_WEB, 1'b1);
    check({tag, "_a"},   sram_A,   '0);
    check({tag, "_d"},   sram_D,   '0);
    check({tag, "_wrdy"}, w_ready, 1'b0);
    check({tag, "_rrdy"}, r_ready, 1'b0);
    check({tag, "_rspv"}, resp_valid, 1'b0);
    check({tag, "_done"}, init_done, 1'b0);
  endtask

  // Expects reset released at this point; runs the full INIT sequence
  task automatic check_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check({tag, "_ceb"}, sram_CEB, 1'b0);
      check({tag, "_web"}, sram_WEB, 1'b0);
      check({tag, "_a"},   sram_A,   DATA_W'(i));
      check({tag, "_d"},   sram_D,   '0);
      check({tag, "_wrdy"}, w_ready, 1'b0);
      check({tag, "_done"}, init_done, 1'b0);
      step();
    end
    #1;
    check({tag, "_done_rise"}, init_done, 1'b1);
    check({tag, "_state_run"}, dbg_state, 1'b1);
    check({tag, "_wrdy_run"}, w_ready, 1'b1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    w_valid = 1'b1; w_addr = a; w_data = d;
    #1;
    check("wr_web", sram_WEB, 1'b0);
    check("wr_a", sram_A, DATA_W'(a));
    step();
    w_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    resp_ready = 1'b1;
    #12;
    check_idle_pins("rst");
    check("rst_state", dbg_state, 1'b0);
    step();
    reset = 1'b0;
    check_init("init");

    // Write / read back
    do_write(2'd2, 334'h5A5A);
    r_valid = 1'b1; r_addr = 2'd2;
    #1;
    check("rb_rrdy", r_ready, 1'b1);
    check("rb_ceb", sram_CEB, 1'b0);
    check("rb_web", sram_WEB, 1'b1);
    check("rb_rspv_early", resp_valid, 1'b0);
    step();
    r_addr = 2'd3;
    #1;
    check("rb_rspv", resp_valid, 1'b1);
    check("rb_data", resp_data, 334'h5A5A);
    check("rb_rrdy2", r_ready, 1'b1);
    step();
    r_valid = 1'b0;
    #1;
    check("rb_zero_v", resp_valid, 1'b1);
    check("rb_zero_d", resp_data, '0);
    step();
    #1;
    check("rb_done_v", resp_valid, 1'b0);

    // Streaming reads
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(i + 1));
    for (int i = 0; i < DEPTH; i++) begin
      r_valid = 1'b1; r_addr = ADDR_W'(i);
      #1;
      check("st_rrdy", r_ready, 1'b1);
      if (i > 0) check("st_data", resp_data, DATA_W'(i));
      if (i > 0) check("st_v", resp_valid, 1'b1);
      step();
    end
    r_valid = 1'b0;
    #1;
    check("st_last", resp_data, DATA_W'(4));
    step();
    #1;
    check("st_end_v", resp_valid, 1'b0);

    // Backpressure
    do_write(2'd1, 334'h7);
    r_valid = 1'b1; r_addr = 2'd1; resp_ready = 1'b0;
    #1;
    check("bp_fire", r_ready, 1'b1);
    step();
    r_addr = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_v", resp_valid, 1'b1);
      check("bp_data", resp_data, 334'h7);
      check("bp_rrdy", r_ready, 1'b0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_rel_v", resp_valid, 1'b1);
    check("bp_rel_d", resp_data, 334'h7);
    check("bp_rel_rrdy", r_ready, 1'b0);
    step();
    #1;
    check("bp_once", resp_valid, 1'b0);
    check("bp_rrdy_back", r_ready, 1'b1);
    step();
    r_valid = 1'b0;
    #1;
    check("bp_next_v", resp_valid, 1'b1);
    check("bp_next_d", resp_data, DATA_W'(1));
    step();

    // Collision: write wins twice, read fires third cycle
    r_valid = 1'b1; r_addr = 2'd3;
    w_valid = 1'b1; w_addr = 2'd3; w_data = 334'h11;
    #1;
    check("col1_web", sram_WEB, 1'b0);
    check("col1_d", sram_D, 334'h11);
    check("col1_rrdy", r_ready, 1'b0);
    step();
    w_data = 334'h22;
    #1;
    check("col2_web", sram_WEB, 1'b0);
    check("col2_rrdy", r_ready, 1'b0);
    step();
    w_valid = 1'b0;
    #1;
    check("col3_rrdy", r_ready, 1'b1);
    check("col3_web", sram_WEB, 1'b1);
    check("col3_ceb", sram_CEB, 1'b0);
    step();
    r_valid = 1'b0;
    #1;
    check("col_resp", resp_data, 334'h22);
    check("col_resp_v", resp_valid, 1'b1);
    step();

    // Reset mid-INIT
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    check("mi_a2", sram_A, DATA_W'(2));
    reset = 1'b1;
    #1;
    check_idle_pins("mi_rst");
    step();
    reset = 1'b0;
    check_init("reinit");

    // Reset mid-hold
    r_valid = 1'b1; r_addr = 2'd1; resp_ready = 1'b0;
    step();
    r_valid = 1'b0;
    step();
    check("mh_hold_v", resp_valid, 1'b1);
    check("mh_hold_d", resp_data, '0);
    reset = 1'b1;
    #1;
    check("mh_rst_v", resp_valid, 1'b0);
    step();
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("mh_after_v", resp_valid, 1'b0);
    check("mh_after_a", sram_A, '0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
